// File: rtl/pe_result_drain_if.sv
// Cube-side capture bus plus the drained valid/ready result stream.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface pe_result_drain_if #(
    parameter int LANES  = 27,
    parameter int LANE_W = 5
);
    logic [8*LANES-1:0] iResult;
    logic [LANES-1:0]   iResultValid;
    logic [7:0]         oData;
    logic [LANE_W-1:0]  oLane;
    logic               oValid;
    logic               iReady;

    modport master (
        output iResult, iResultValid, iReady,
        input  oData, oLane, oValid
    );

    modport slave (
        input  iResult, iResultValid, iReady,
        output oData, oLane, oValid
    );
endinterface

// File: rtl/pe_result_drain.sv
// Captures per-lane PE cube results into holding registers and drains them
// one lane per beat over a valid/ready stream with round-robin arbitration.
module pe_drain_lane (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       cap_en,
    input  logic [7:0] cap_data,
    input  logic       load_sel,
    output logic [7:0] hold,
    output logic       pend,
    output logic       ovf_evt
);
    logic [7:0] hold_q, hold_d;
    logic       pend_q, pend_d;

    // A capture in the same cycle as this lane's load re-arms the lane.
    always_comb begin
        hold_d = hold_q;
        pend_d = pend_q;
        if (load_sel) pend_d = 1'b0;
        if (cap_en) begin
            hold_d = cap_data;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            hold_q <= '0;
            pend_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            pend_q <= pend_d;
        end
    end

    assign hold    = hold_q;
    assign pend    = pend_q;
    assign ovf_evt = cap_en & pend_q & ~load_sel;
endmodule

module pe_result_drain #(
    parameter int  CUBE_NUM  = 3,
    parameter int  BLOCK_NUM = 3,
    parameter int  ARRAY_NUM = 3,
    parameter int  LANE_W    = 5,
    localparam int LANES     = CUBE_NUM * BLOCK_NUM * ARRAY_NUM
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iClearOverflow,
    output logic                 oOverflow,
    output logic                 oBusy,
    pe_result_drain_if.slave     bus
);
    logic [LANES-1:0]        pend;
    logic [LANES-1:0]        ovf_evt;
    logic [LANES-1:0]        load_sel;
    logic [LANES-1:0][7:0]   hold;

    logic [LANE_W-1:0] rr_q, rr_d;
    logic [7:0]        data_q, data_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;

    logic [LANE_W-1:0] sel_idx;
    logic [LANE_W:0]   idx;
    logic              found;
    logic              load_en;
    logic              load_fire;

    assign load_en   = ~valid_q | bus.iReady;
    assign load_fire = load_en & found;

    // Rotating priority search starting at rr, wrapping at LANES.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        idx     = '0;
        for (int i = 0; i < LANES; i++) begin
            idx = {1'b0, rr_q} + (LANE_W+1)'(i);
            if (idx >= (LANE_W+1)'(LANES)) idx = idx - (LANE_W+1)'(LANES);
            if (!found && pend[idx[LANE_W-1:0]]) begin
                found   = 1'b1;
                sel_idx = idx[LANE_W-1:0];
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign load_sel[k] = load_fire && (sel_idx == LANE_W'(k));

        pe_drain_lane u_lane (
            .iClk     (iClk),
            .iRst     (iRst),
            .cap_en   (bus.iResultValid[k]),
            .cap_data (bus.iResult[8*k +: 8]),
            .load_sel (load_sel[k]),
            .hold     (hold[k]),
            .pend     (pend[k]),
            .ovf_evt  (ovf_evt[k])
        );
    end

    always_comb begin
        data_d  = data_q;
        lane_d  = lane_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        if (load_fire) begin
            data_d  = hold[sel_idx];
            lane_d  = sel_idx;
            valid_d = 1'b1;
            rr_d    = (sel_idx == LANE_W'(LANES-1)) ? '0 : sel_idx + LANE_W'(1);
        end else if (load_en) begin
            valid_d = 1'b0;
        end
    end

    // A fresh overflow outranks a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (|ovf_evt)            ovf_d = 1'b1;
        else if (iClearOverflow) ovf_d = 1'b0;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            data_q  <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
            rr_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.oData  = data_q;
    assign bus.oLane  = lane_q;
    assign bus.oValid = valid_q;
    assign oOverflow  = ovf_q;
    assign oBusy      = (|pend) | valid_q;
endmodule

// File: tb/tb_pe_result_drain.sv
// Directed and randomized checks of pe_result_drain against a queue/array
// reference model evaluated once per rising edge.
module tb_pe_result_drain;
    localparam int L = 27;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    logic iClearOverflow = 1'b0;
    logic oOverflow, oBusy;
    int   n_checks = 0;
    int   n_err = 0;

    pe_result_drain_if #(.LANES(L), .LANE_W(5)) bus();

    pe_result_drain dut (
        .iClk           (iClk),
        .iRst           (iRst),
        .iClearOverflow (iClearOverflow),
        .oOverflow      (oOverflow),
        .oBusy          (oBusy),
        .bus            (bus)
    );

    always #5 iClk = ~iClk;

    // Reference model state
    bit         m_pend [L];
    logic [7:0] m_hold [L];
    int         m_rr;
    logic [7:0] m_data;
    int         m_lane;
    bit         m_valid;
    bit         m_ovf;

    always @(posedge iClk) begin : model
        int sel;
        bit ld, ovf_new;
        if (iRst) begin
            for (int k = 0; k < L; k++) begin m_pend[k] = 0; m_hold[k] = 8'h00; end
            m_rr = 0; m_data = 8'h00; m_lane = 0; m_valid = 0; m_ovf = 0;
        end else begin
            ld  = !m_valid || bus.iReady;
            sel = -1;
            if (ld) begin
                for (int i = 0; i < L; i++) begin
                    if (sel < 0 && m_pend[(m_rr + i) % L]) sel = (m_rr + i) % L;
                end
            end
            ovf_new = 0;
            for (int k = 0; k < L; k++)
                if (bus.iResultValid[k] && m_pend[k] && k != sel) ovf_new = 1;
            if (sel >= 0) begin
                m_data = m_hold[sel]; m_lane = sel; m_valid = 1;
                m_pend[sel] = 0; m_rr = (sel + 1) % L;
            end else if (ld) begin
                m_valid = 0;
            end
            for (int k = 0; k < L; k++) begin
                if (bus.iResultValid[k]) begin
                    m_hold[k] = bus.iResult[8*k +: 8];
                    m_pend[k] = 1;
                end
            end
            if (ovf_new) m_ovf = 1;
            else if (iClearOverflow) m_ovf = 0;
        end
    end

    task automatic step();
        @(posedge iClk);
        @(negedge iClk);
    endtask

    task automatic do_reset();
        bus.iResultValid = '0;
        iClearOverflow = 1'b0;
        iRst = 1'b1;
        step();
        iRst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.oValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", bus.oValid); end
        n_checks++; if (bus.oData !== 8'h00) begin n_err++; $display("FAIL reset_data: got %0h expected 0", bus.oData); end
        n_checks++; if (bus.oLane !== 5'd0) begin n_err++; $display("FAIL reset_lane: got %0d expected 0", bus.oLane); end
        n_checks++; if (oOverflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b expected 0", oOverflow); end
        n_checks++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", oBusy); end
    endtask

    task automatic test_single();
        do_reset();
        bus.iReady = 1'b1;
        bus.iResult[8*5 +: 8] = 8'hA7;
        bus.iResultValid = L'(1) << 5;
        step();
        bus.iResultValid = '0;
        n_checks++; if (bus.oValid !== 1'b0 || oBusy !== 1'b1) begin n_err++; $display("FAIL single_capture: got valid=%0b busy=%0b expected valid=0 busy=1", bus.oValid, oBusy); end
        step();
        n_checks++; if (bus.oValid !== 1'b1 || bus.oData !== 8'hA7 || bus.oLane !== 5'd5) begin n_err++; $display("FAIL single_beat: got v=%0b d=%0h l=%0d expected v=1 d=a7 l=5", bus.oValid, bus.oData, bus.oLane); end
        step();
        n_checks++; if (bus.oValid !== 1'b0 || oBusy !== 1'b0) begin n_err++; $display("FAIL single_idle: got valid=%0b busy=%0b expected 0 0", bus.oValid, oBusy); end
    endtask

    task automatic test_burst();
        do_reset();
        bus.iReady = 1'b1;
        for (int k = 0; k < L; k++) bus.iResult[8*k +: 8] = 8'(k + 1);
        bus.iResultValid = '1;
        step();
        bus.iResultValid = '0;
        for (int k = 0; k < L; k++) begin
            step();
            n_checks++; if (bus.oValid !== 1'b1 || bus.oLane !== 5'(k) || bus.oData !== 8'(k + 1)) begin n_err++; $display("FAIL burst_beat%0d: got v=%0b l=%0d d=%0h expected v=1 l=%0d d=%0h", k, bus.oValid, bus.oLane, bus.oData, k, k + 1); end
        end
        n_checks++; if (oOverflow !== 1'b0) begin n_err++; $display("FAIL burst_ovf: got %0b expected 0", oOverflow); end
        step();
        n_checks++; if (bus.oValid !== 1'b0 || oBusy !== 1'b0) begin n_err++; $display("FAIL burst_end: got valid=%0b busy=%0b expected 0 0", bus.oValid, oBusy); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.iReady = 1'b1;
        bus.iResult[8*9 +: 8] = 8'h99;
        bus.iResultValid = L'(1) << 9;
        step();
        bus.iResultValid = '0;
        step();
        n_checks++; if (bus.oLane !== 5'd9 || bus.oValid !== 1'b1) begin n_err++; $display("FAIL rr_seed: got l=%0d v=%0b expected l=9 v=1", bus.oLane, bus.oValid); end
        bus.iResult[8*2 +: 8]  = 8'h22;
        bus.iResult[8*20 +: 8] = 8'hA0;
        bus.iResultValid = (L'(1) << 2) | (L'(1) << 20);
        step();
        bus.iResultValid = '0;
        step();
        n_checks++; if (bus.oLane !== 5'd20 || bus.oData !== 8'hA0) begin n_err++; $display("FAIL rr_first: got l=%0d d=%0h expected l=20 d=a0", bus.oLane, bus.oData); end
        step();
        n_checks++; if (bus.oLane !== 5'd2 || bus.oData !== 8'h22) begin n_err++; $display("FAIL rr_second: got l=%0d d=%0h expected l=2 d=22", bus.oLane, bus.oData); end
        // rr should now be 3, so lane 3 beats lane 2
        bus.iResult[8*2 +: 8] = 8'h02;
        bus.iResult[8*3 +: 8] = 8'h03;
        bus.iResultValid = (L'(1) << 2) | (L'(1) << 3);
        step();
        bus.iResultValid = '0;
        step();
        n_checks++; if (bus.oLane !== 5'd3 || bus.oData !== 8'h03) begin n_err++; $display("FAIL rr_ptr3_first: got l=%0d d=%0h expected l=3 d=03", bus.oLane, bus.oData); end
        step();
        n_checks++; if (bus.oLane !== 5'd2 || bus.oData !== 8'h02) begin n_err++; $display("FAIL rr_ptr3_second: got l=%0d d=%0h expected l=2 d=02", bus.oLane, bus.oData); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        bus.iReady = 1'b0;
        bus.iResult[7:0] = 8'h11;
        bus.iResultValid = L'(1);
        step();
        bus.iResultValid = '0;
        step();
        n_checks++; if (bus.oValid !== 1'b1 || bus.oData !== 8'h11 || bus.oLane !== 5'd0) begin n_err++; $display("FAIL bp_present: got v=%0b d=%0h l=%0d expected 1 11 0", bus.oValid, bus.oData, bus.oLane); end
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++; if (bus.oValid !== 1'b1 || bus.oData !== 8'h11 || bus.oLane !== 5'd0) begin n_err++; $display("FAIL bp_hold%0d: got v=%0b d=%0h l=%0d expected 1 11 0", c, bus.oValid, bus.oData, bus.oLane); end
        end
        bus.iReady = 1'b1;
        step();
        n_checks++; if (bus.oValid !== 1'b0 || oBusy !== 1'b0) begin n_err++; $display("FAIL bp_release: got valid=%0b busy=%0b expected 0 0", bus.oValid, oBusy); end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.iReady = 1'b0;
        bus.iResult[7:0] = 8'h55;
        bus.iResultValid = L'(1);
        step();
        bus.iResultValid = '0;
        step();
        bus.iResult[8*3 +: 8] = 8'h10;
        bus.iResultValid = L'(1) << 3;
        step();
        n_checks++; if (oOverflow !== 1'b0) begin n_err++; $display("FAIL ovf_first_capture: got %0b expected 0", oOverflow); end
        bus.iResult[8*3 +: 8] = 8'h20;
        step();
        bus.iResultValid = '0;
        n_checks++; if (oOverflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %0b expected 1", oOverflow); end
        bus.iReady = 1'b1;
        step();
        n_checks++; if (bus.oValid !== 1'b1 || bus.oLane !== 5'd3 || bus.oData !== 8'h20) begin n_err++; $display("FAIL ovf_drained: got v=%0b l=%0d d=%0h expected 1 3 20", bus.oValid, bus.oLane, bus.oData); end
        bus.iReady = 1'b0;
        iClearOverflow = 1'b1;
        step();
        iClearOverflow = 1'b0;
        n_checks++; if (oOverflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %0b expected 0", oOverflow); end
        bus.iResult[8*3 +: 8] = 8'h30;
        bus.iResultValid = L'(1) << 3;
        step();
        bus.iResult[8*3 +: 8] = 8'h40;
        iClearOverflow = 1'b1;
        step();
        bus.iResultValid = '0;
        iClearOverflow = 1'b0;
        n_checks++; if (oOverflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_beats_clear: got %0b expected 1", oOverflow); end
        bus.iReady = 1'b1;
        step();
        n_checks++; if (bus.oValid !== 1'b1 || bus.oData !== 8'h40) begin n_err++; $display("FAIL ovf_second_drain: got v=%0b d=%0h expected 1 40", bus.oValid, bus.oData); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.iReady = 1'b0;
        for (int k = 0; k < 10; k++) bus.iResult[8*k +: 8] = 8'($urandom);
        bus.iResultValid = L'(10'h3FF);
        step();
        bus.iResultValid = '0;
        step();
        bus.iResultValid = L'(10'h3FF);
        step();
        bus.iResultValid = '0;
        n_checks++; if (bus.oValid !== 1'b1 || oOverflow !== 1'b1) begin n_err++; $display("FAIL mid_pre: got v=%0b ovf=%0b expected 1 1", bus.oValid, oOverflow); end
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        n_checks++; if (bus.oValid !== 1'b0 || oBusy !== 1'b0 || oOverflow !== 1'b0) begin n_err++; $display("FAIL mid_reset: got v=%0b busy=%0b ovf=%0b expected 0 0 0", bus.oValid, oBusy, oOverflow); end
        bus.iReady = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++; if (bus.oValid !== 1'b0) begin n_err++; $display("FAIL mid_no_beat%0d: got %0b expected 0", c, bus.oValid); end
        end
        bus.iResult[8*1 +: 8]  = 8'h01;
        bus.iResult[8*20 +: 8] = 8'h14;
        bus.iResultValid = (L'(1) << 1) | (L'(1) << 20);
        step();
        bus.iResultValid = '0;
        step();
        n_checks++; if (bus.oLane !== 5'd1 || bus.oData !== 8'h01) begin n_err++; $display("FAIL mid_rr0_first: got l=%0d d=%0h expected 1 01", bus.oLane, bus.oData); end
        step();
        n_checks++; if (bus.oLane !== 5'd20 || bus.oData !== 8'h14) begin n_err++; $display("FAIL mid_rr0_second: got l=%0d d=%0h expected 20 14", bus.oLane, bus.oData); end
    endtask

    task automatic test_random();
        bit exp_busy;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < L; k++) begin
                bus.iResult[8*k +: 8]  = 8'($urandom);
                bus.iResultValid[k]    = ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 39) == 0) bus.iResultValid = '1;
            bus.iReady     = ($urandom_range(0, 9) < 7);
            iClearOverflow = ($urandom_range(0, 14) == 0);
            step();
            exp_busy = m_valid;
            for (int k = 0; k < L; k++) if (m_pend[k]) exp_busy = 1;
            n_checks++; if (bus.oValid !== m_valid) begin n_err++; $display("FAIL rand_valid c%0d: got %0b expected %0b", c, bus.oValid, m_valid); end
            if (m_valid) begin
                n_checks++; if (bus.oData !== m_data || bus.oLane !== 5'(m_lane)) begin n_err++; $display("FAIL rand_beat c%0d: got d=%0h l=%0d expected d=%0h l=%0d", c, bus.oData, bus.oLane, m_data, m_lane); end
            end
            n_checks++; if (oOverflow !== m_ovf) begin n_err++; $display("FAIL rand_ovf c%0d: got %0b expected %0b", c, oOverflow, m_ovf); end
            n_checks++; if (oBusy !== exp_busy) begin n_err++; $display("FAIL rand_busy c%0d: got %0b expected %0b", c, oBusy, exp_busy); end
        end
        bus.iResultValid = '0;
        iClearOverflow = 1'b0;
    endtask

    initial begin
        bus.iResult = '0;
        bus.iResultValid = '0;
        bus.iReady = 1'b1;
        @(negedge iClk);
        test_reset();
        test_single();
        test_burst();
        test_round_robin();
        test_back_pressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
